// File: rtl/shift_compute_pkg.sv
// Shared constants, control-bus bit positions and latch-operation encoding
// for the bit-serial compute tile.
package shift_compute_pkg;

  // Operand/register width; the 8-bit ui/uo buses fix this at 8.
  localparam int WIDTH = 8;
  // Register-bank depth; addressed by the 3-bit select field.
  localparam int NREGS = 8;
  localparam int SEL_W = 3;

  // Bit positions inside ui_in.
  localparam int DATA    = 0;
  localparam int SEL_LSB = 1;
  localparam int SEL_MSB = 3;
  localparam int ADD     = 4;
  localparam int AND     = 5;

  // Latch operation, encoded directly as {latch_and, latch_add}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_AND  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Map the two latch strobes onto an operation.
  function automatic op_e decode_op(input logic latch_add, input logic latch_and);
    op_e op;
    case ({latch_and, latch_add})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_AND;
      2'b11:   op = OP_LOAD;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/shift_compute_alu.sv
// Combinational next-value logic for one bank register: the current
// register value r combined with the shifted operand s under op.
module shift_compute_alu
  import shift_compute_pkg::*;
(
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  // Select the combined value; add wraps because the sum is truncated to WIDTH.
  always_comb begin
    result = r;
    case (op)
      OP_ADD:  result = r + s;
      OP_AND:  result = r & s;
      OP_LOAD: result = s;
      default: result = r;
    endcase
  end

endmodule

// File: rtl/shift_compute.sv
// Bit-serial compute tile: an operand is shifted in MSB first, then latch
// strobes fold it into one of eight bank registers. The bank register picked
// by select is always visible on uo_out.
module shift_compute
  import shift_compute_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  logic             data_in;
  logic [SEL_W-1:0] sel;
  logic             latch_add;
  logic             latch_and;
  op_e              op;

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] bank_q [NREGS];
  logic [WIDTH-1:0] alu_result;

  // ui_in[7:6] are spare bits of the tile bus and deliberately ignored.
  logic unused_ui;
  assign unused_ui = ^ui_in[7:6];

  assign data_in   = ui_in[DATA];
  assign sel       = ui_in[SEL_MSB:SEL_LSB];
  assign latch_add = ui_in[ADD];
  assign latch_and = ui_in[AND];
  assign op        = decode_op(latch_add, latch_and);

  // The ALU sees the shift register as it was before this edge, so the
  // data_in bit arriving in a latch cycle starts the next operand instead.
  shift_compute_alu u_alu (
    .r      (bank_q[sel]),
    .s      (shift_q),
    .op     (op),
    .result (alu_result)
  );

  // Operand shift register: shifts every cycle, including latch cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= {shift_q[WIDTH-2:0], data_in};
    end
  end

  // Register bank: only the selected entry is written, and only on a latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (op != OP_NONE) begin
      bank_q[sel] <= alu_result;
    end
  end

  // Output mux follows select with no clock involved.
  always_comb begin
    uo_out = bank_q[sel];
  end

endmodule

// File: tb/tb_shift_compute.sv
// Bench for shift_compute: directed scenarios followed by random traffic,
// all checked against a behavioural model of the operand and register bank.
module tb_shift_compute;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the operand is "last eight bits as a number", the
  // bank is a plain array of bytes.
  int         operand_m;
  logic [7:0] regs_m [8];
  logic [7:0] exp_q [$];

  // Clock / reset block.
  always #5 clk = ~clk;

  shift_compute dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check the combinational
  // view before the rising edge, update the model, then check afterwards.
  task automatic step(input logic d, input logic [2:0] sel, input logic add,
                      input logic lat_and, input logic r);
    int sum;
    @(negedge clk);
    ui_in = {2'($urandom_range(0, 3)), lat_and, add, sel, d};
    rst   = r;
    #1;
    exp_q.push_back(regs_m[sel]);
    check_eq("pre_edge", uo_out, exp_q.pop_front());
    @(posedge clk);
    if (r) begin
      operand_m = 0;
      foreach (regs_m[i]) regs_m[i] = 8'h00;
    end else begin
      if (add && lat_and) begin
        regs_m[sel] = 8'(operand_m);
      end else if (add) begin
        sum = (int'(regs_m[sel]) + operand_m) % 256;
        regs_m[sel] = 8'(sum);
      end else if (lat_and) begin
        regs_m[sel] = regs_m[sel] & 8'(operand_m);
      end
      operand_m = (operand_m * 2 + int'(d)) % 256;
    end
    #1;
    exp_q.push_back(regs_m[sel]);
    check_eq("post_edge", uo_out, exp_q.pop_front());
  endtask

  // Shift a byte MSB first with no latch.
  task automatic shift_byte(input logic [7:0] val, input logic [2:0] sel);
    for (int i = 7; i >= 0; i--) step(val[i], sel, 1'b0, 1'b0, 1'b0);
  endtask

  // Idle cycle on sel, then compare the output to a hand-derived constant.
  task automatic view(input logic [2:0] sel, input string tag, input logic [7:0] exp);
    step(1'($urandom_range(0, 1)), sel, 1'b0, 1'b0, 1'b0);
    check_eq(tag, uo_out, exp);
  endtask

  initial begin
    rst       = 1'b1;
    ui_in     = 8'h00;
    operand_m = 0;
    foreach (regs_m[i]) regs_m[i] = 8'h00;

    // Reset held for two cycles, then every select reads zero.
    step(1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) view(3'(k), "reset_sel", 8'h00);

    // Add 0x35 into R2.
    shift_byte(8'h35, 3'd0);
    step(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    view(3'd2, "add_r2", 8'h35);
    view(3'd0, "add_r0", 8'h00);

    // Wrapping add: 0x35 + 0xF0 = 0x25.
    shift_byte(8'hF0, 3'd2);
    step(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    view(3'd2, "add_wrap", 8'h25);

    // AND: 0x25 & 0x0F = 0x05.
    shift_byte(8'h0F, 3'd4);
    step(1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    view(3'd2, "and_r2", 8'h05);

    // Load 0xA5 into R7.
    shift_byte(8'hA5, 3'd7);
    step(1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
    view(3'd7, "load_r7", 8'hA5);

    // Operand excludes the bit sampled in the latch cycle.
    shift_byte(8'h80, 3'd1);
    step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    view(3'd1, "timing_r1", 8'h80);
    view(3'd2, "iso_r2", 8'h05);
    view(3'd7, "iso_r7", 8'hA5);
    view(3'd0, "iso_r0", 8'h00);

    // Reset in the middle of an operand discards it.
    for (int i = 0; i < 4; i++) step(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
    shift_byte(8'h11, 3'd3);
    step(1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    view(3'd3, "midrst_r3", 8'h11);
    view(3'd2, "midrst_r2", 8'h00);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 79) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
